dcache_port_arbiter: RTL and testbench
======================================

DCACHE_PORT_ARBITER -- requirements
Module: dcache_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, request address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, data width; byte-enable width is DATA_WIDTH/8.
REQ-003 SHALL have parameter MAX_WAIT, default 4, the number of consecutive PTW grants after which a pending LSU request wins.
REQ-004 SHALL use one clock and a synchronous, active-high reset, with ports as follows.
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  synchronous active-high reset.
REQ-005 SHALL provide requester 0 (PTW) ports:
- ptw_req_i  in  1  request.
- ptw_addr_i  in  ADDR_WIDTH  address.
- ptw_we_i  in  1  write enable.
- ptw_be_i  in  DATA_WIDTH/8  byte enables.
- ptw_wdata_i  in  DATA_WIDTH  write data.
- ptw_gnt_o  out  1  grant.
- ptw_rvalid_o  out  1  response valid.
- ptw_rdata_o  out  DATA_WIDTH  response data.
- ptw_err_o  out  1  response error.
REQ-006 SHALL provide requester 1 (LSU) ports lsu_req_i, lsu_addr_i, lsu_we_i, lsu_be_i, lsu_wdata_i, lsu_gnt_o, lsu_rvalid_o, lsu_rdata_o and lsu_err_o, with the same directions, widths and meanings as REQ-005.
REQ-007 SHALL provide the cache-side ports:
- dc_req_o  out  1  request to cache.
- dc_addr_o  out  ADDR_WIDTH  address.
- dc_we_o  out  1  write enable.
- dc_be_o  out  DATA_WIDTH/8  byte enables.
- dc_wdata_o  out  DATA_WIDTH  write data.
- dc_gnt_i  in  1  cache accepted the request.
- dc_rvalid_i  in  1  cache response valid.
- dc_rdata_i  in  DATA_WIDTH  response data.
- dc_err_i  in  1  response error.
REQ-008 SHALL provide status outputs:
- busy_o  out  1  state is not IDLE.
- owner_o  out  1  owner of the current transaction; 0 = PTW, 1 = LSU.
- spurious_o  out  1  one-cycle pulse on an unexpected dc_rvalid_i.

Function
REQ-009 SHALL implement the FSM states IDLE, ISSUE and WAIT_RSP, with at most one transaction outstanding.
REQ-010 In IDLE with any requester's req_i high, SHALL select a winner, latch the winner's addr, we, be and wdata into registers, pulse that requester's gnt_o for one cycle in the same cycle, and move to ISSUE.
REQ-011 Arbitration SHALL give priority to PTW, except that LSU wins when both request and lsu_wait_cnt == MAX_WAIT.
REQ-012 lsu_wait_cnt SHALL increment, saturating at MAX_WAIT, on each PTW grant issued while lsu_req_i is high.
REQ-013 lsu_wait_cnt SHALL clear to 0 on each LSU grant.
REQ-014 Requesters hold req_i and the request fields stable until gnt_o; after gnt_o the arbiter SHALL ignore those inputs for the current transaction.
REQ-015 In ISSUE, SHALL drive dc_req_o=1 and the dc_* fields from the latched registers, held stable until dc_gnt_i is high, then move to WAIT_RSP.
REQ-016 dc_req_o SHALL be 0 in IDLE and in WAIT_RSP.
REQ-017 In WAIT_RSP on dc_rvalid_i, SHALL drive the owner's rvalid_o=1, rdata_o=dc_rdata_i and err_o=dc_err_i combinationally in that same cycle, then move to IDLE.
REQ-018 The non-owner's rvalid_o and err_o SHALL stay 0 at all times; rdata_o of both requesters may show dc_rdata_i.
REQ-019 dc_rvalid_i in IDLE or ISSUE SHALL be ignored (no rvalid_o to either requester) and SHALL pulse spurious_o for one cycle.
REQ-020 Minimum transaction length SHALL be 3 cycles (IDLE grant, ISSUE, WAIT_RSP); there is no back-to-back arbitration from WAIT_RSP.
REQ-021 owner_o SHALL update at grant and hold until return to IDLE.
REQ-022 A requester whose req_i drops before grant SHALL simply not be granted.
REQ-023 Stores follow the same protocol; the store completion response is dc_rvalid_i with rdata don't-care.

Reset
REQ-024 On rst_i high at a clock edge, SHALL go to IDLE and clear lsu_wait_cnt, owner_o and the latched request registers to 0, whatever state it is in.
REQ-025 From the cycle after reset, SHALL hold dc_req_o, all gnt_o, all rvalid_o, all err_o, spurious_o and busy_o at 0.
REQ-026 A response arriving after a mid-transaction reset SHALL be treated as spurious (REQ-019).

Verification
REQ-027 LSU only: LSU read of 0x0000_1004, dc_gnt_i one cycle after dc_req_o, dc_rdata_i=0xDEADBEEF -> lsu_gnt_o at cycle 0, dc_req_o at cycle 1, lsu_rvalid_o with 0xDEADBEEF at cycle 3, ptw_rvalid_o stays 0.
REQ-028 Both requesting in the same cycle with lsu_wait_cnt=0 -> PTW is granted first and LSU second; owner_o is 0 then 1.
REQ-029 Starvation: PTW requests continuously, LSU holds req_i, MAX_WAIT=4 -> after 4 PTW grants the 5th grant goes to LSU and lsu_wait_cnt returns to 0.
REQ-030 Cache stall: dc_gnt_i held low for 10 cycles -> dc_req_o and dc_addr_o/dc_we_o/dc_be_o/dc_wdata_o stay stable for all 10 cycles, with no new grant to either requester.
REQ-031 Reset during WAIT_RSP, then dc_rvalid_i one cycle later -> state is IDLE, spurious_o pulses, no rvalid_o to either requester.
REQ-032 LSU store of 0x0000_00FF, be=4'b0001, dc_err_i=1 on response -> dc_we_o=1, dc_be_o=4'b0001, lsu_err_o=1 together with lsu_rvalid_o.

Source files
------------

// File: rtl/dcache_port_arbiter.sv
// Two-requester data-cache port arbiter (PTW, LSU) with one transaction in flight.
// PTW has priority; a waiting LSU is promoted after MAX_WAIT PTW grants.
module dcache_port_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_WAIT   = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    ptw_req_i,
  input  logic [ADDR_WIDTH-1:0]   ptw_addr_i,
  input  logic                    ptw_we_i,
  input  logic [DATA_WIDTH/8-1:0] ptw_be_i,
  input  logic [DATA_WIDTH-1:0]   ptw_wdata_i,
  output logic                    ptw_gnt_o,
  output logic                    ptw_rvalid_o,
  output logic [DATA_WIDTH-1:0]   ptw_rdata_o,
  output logic                    ptw_err_o,
  input  logic                    lsu_req_i,
  input  logic [ADDR_WIDTH-1:0]   lsu_addr_i,
  input  logic                    lsu_we_i,
  input  logic [DATA_WIDTH/8-1:0] lsu_be_i,
  input  logic [DATA_WIDTH-1:0]   lsu_wdata_i,
  output logic                    lsu_gnt_o,
  output logic                    lsu_rvalid_o,
  output logic [DATA_WIDTH-1:0]   lsu_rdata_o,
  output logic                    lsu_err_o,
  output logic                    dc_req_o,
  output logic [ADDR_WIDTH-1:0]   dc_addr_o,
  output logic                    dc_we_o,
  output logic [DATA_WIDTH/8-1:0] dc_be_o,
  output logic [DATA_WIDTH-1:0]   dc_wdata_o,
  input  logic                    dc_gnt_i,
  input  logic                    dc_rvalid_i,
  input  logic [DATA_WIDTH-1:0]   dc_rdata_i,
  input  logic                    dc_err_i,
  output logic                    busy_o,
  output logic                    owner_o,
  output logic                    spurious_o
);
  // state    | meaning
  // IDLE     | no transaction; arbitrate, grant and latch the winner
  // ISSUE    | present latched request to the cache until dc_gnt_i
  // WAIT_RSP | wait for dc_rvalid_i and route it to the owner

  localparam int BE_WIDTH  = DATA_WIDTH / 8;
  localparam int CNT_WIDTH = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(MAX_WAIT);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RSP} state_e;

  state_e                state_q, state_d;
  logic                  owner_q, owner_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  we_q, we_d;
  logic [BE_WIDTH-1:0]   be_q, be_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [CNT_WIDTH-1:0]  wait_cnt_q, wait_cnt_d;
  logic                  lsu_wins;

  assign lsu_wins = lsu_req_i && (!ptw_req_i || (wait_cnt_q == CNT_MAX));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      owner_q    <= 1'b0;
      addr_q     <= '0;
      we_q       <= 1'b0;
      be_q       <= '0;
      wdata_q    <= '0;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      be_q       <= be_d;
      wdata_q    <= wdata_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    addr_d       = addr_q;
    we_d         = we_q;
    be_d         = be_q;
    wdata_d      = wdata_q;
    wait_cnt_d   = wait_cnt_q;
    ptw_gnt_o    = 1'b0;
    lsu_gnt_o    = 1'b0;
    ptw_rvalid_o = 1'b0;
    lsu_rvalid_o = 1'b0;
    ptw_err_o    = 1'b0;
    lsu_err_o    = 1'b0;
    dc_req_o     = 1'b0;
    spurious_o   = 1'b0;
    case (state_q)
      IDLE: begin
        spurious_o = dc_rvalid_i;
        if (ptw_req_i || lsu_req_i) begin
          state_d = ISSUE;
          owner_d = lsu_wins;
          if (lsu_wins) begin
            lsu_gnt_o  = 1'b1;
            addr_d     = lsu_addr_i;
            we_d       = lsu_we_i;
            be_d       = lsu_be_i;
            wdata_d    = lsu_wdata_i;
            wait_cnt_d = '0;
          end else begin
            ptw_gnt_o = 1'b1;
            addr_d    = ptw_addr_i;
            we_d      = ptw_we_i;
            be_d      = ptw_be_i;
            wdata_d   = ptw_wdata_i;
            // only count PTW grants the LSU actually had to wait through
            if (lsu_req_i && (wait_cnt_q != CNT_MAX)) wait_cnt_d = wait_cnt_q + 1'b1;
          end
        end
      end
      ISSUE: begin
        dc_req_o   = 1'b1;
        spurious_o = dc_rvalid_i;
        if (dc_gnt_i) state_d = WAIT_RSP;
      end
      WAIT_RSP: begin
        if (dc_rvalid_i) begin
          state_d = IDLE;
          if (owner_q) begin
            lsu_rvalid_o = 1'b1;
            lsu_err_o    = dc_err_i;
          end else begin
            ptw_rvalid_o = 1'b1;
            ptw_err_o    = dc_err_i;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign dc_addr_o   = addr_q;
  assign dc_we_o     = we_q;
  assign dc_be_o     = be_q;
  assign dc_wdata_o  = wdata_q;
  assign ptw_rdata_o = dc_rdata_i;
  assign lsu_rdata_o = dc_rdata_i;
  assign busy_o      = (state_q != IDLE);
  assign owner_o     = owner_q;

endmodule

// File: tb/tb_dcache_port_arbiter.sv
// Bench for dcache_port_arbiter: directed scenarios plus randomized transactions
// checked against a grant-history model of the arbitration rules.
module tb_dcache_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;
  localparam int MW = 4;

  logic clk_i = 1'b0;
  logic rst_i;
  logic ptw_req_i, ptw_we_i, lsu_req_i, lsu_we_i;
  logic [AW-1:0] ptw_addr_i, lsu_addr_i, dc_addr_o;
  logic [BW-1:0] ptw_be_i, lsu_be_i, dc_be_o;
  logic [DW-1:0] ptw_wdata_i, lsu_wdata_i, dc_wdata_o, dc_rdata_i, ptw_rdata_o, lsu_rdata_o;
  logic ptw_gnt_o, ptw_rvalid_o, ptw_err_o, lsu_gnt_o, lsu_rvalid_o, lsu_err_o;
  logic dc_req_o, dc_we_o, dc_gnt_i, dc_rvalid_i, dc_err_i;
  logic busy_o, owner_o, spurious_o;

  always #5 clk_i = ~clk_i;

  dcache_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_WAIT(MW)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .ptw_req_i(ptw_req_i), .ptw_addr_i(ptw_addr_i), .ptw_we_i(ptw_we_i), .ptw_be_i(ptw_be_i),
    .ptw_wdata_i(ptw_wdata_i), .ptw_gnt_o(ptw_gnt_o), .ptw_rvalid_o(ptw_rvalid_o),
    .ptw_rdata_o(ptw_rdata_o), .ptw_err_o(ptw_err_o),
    .lsu_req_i(lsu_req_i), .lsu_addr_i(lsu_addr_i), .lsu_we_i(lsu_we_i), .lsu_be_i(lsu_be_i),
    .lsu_wdata_i(lsu_wdata_i), .lsu_gnt_o(lsu_gnt_o), .lsu_rvalid_o(lsu_rvalid_o),
    .lsu_rdata_o(lsu_rdata_o), .lsu_err_o(lsu_err_o),
    .dc_req_o(dc_req_o), .dc_addr_o(dc_addr_o), .dc_we_o(dc_we_o), .dc_be_o(dc_be_o),
    .dc_wdata_o(dc_wdata_o), .dc_gnt_i(dc_gnt_i), .dc_rvalid_i(dc_rvalid_i),
    .dc_rdata_i(dc_rdata_i), .dc_err_i(dc_err_i),
    .busy_o(busy_o), .owner_o(owner_o), .spurious_o(spurious_o)
  );

  int errors = 0;
  int checks = 0;
  int wait_m = 0;  // PTW grants the LSU has sat through since its last grant

  // observations collected by run_txn
  logic o_pgnt, o_lgnt, o_busy0, o_owner, o_owner_hold, o_busy_ok, o_regrant, o_stable;
  logic o_spur, o_early_rv, o_wait_dcreq, o_p_rv, o_l_rv, o_p_err, o_l_err, o_busy_end, o_we;
  logic [AW-1:0] o_addr;
  logic [BW-1:0] o_be;
  logic [DW-1:0] o_wdata, o_p_rdata, o_l_rdata;

  task automatic idle_inputs();
    ptw_req_i = 0; ptw_addr_i = '0; ptw_we_i = 0; ptw_be_i = '0; ptw_wdata_i = '0;
    lsu_req_i = 0; lsu_addr_i = '0; lsu_we_i = 0; lsu_be_i = '0; lsu_wdata_i = '0;
    dc_gnt_i = 0; dc_rvalid_i = 0; dc_rdata_i = '0; dc_err_i = 0;
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    idle_inputs();
    rst_i = 1;
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 0;
    wait_m = 0;
  endtask

  // Random traffic on the request lines while a transaction is in flight must be ignored.
  task automatic scramble_reqs();
    ptw_req_i = 1'($urandom_range(0, 1)); lsu_req_i = 1'($urandom_range(0, 1));
    ptw_addr_i = $urandom; lsu_addr_i = $urandom; ptw_wdata_i = $urandom; lsu_wdata_i = $urandom;
    ptw_we_i = 1'($urandom_range(0, 1)); lsu_we_i = 1'($urandom_range(0, 1));
    ptw_be_i = BW'($urandom); lsu_be_i = BW'($urandom);
  endtask

  task automatic run_txn(input logic p, input logic l,
                         input logic [AW-1:0] pa, input logic pw, input logic [BW-1:0] pb, input logic [DW-1:0] pd,
                         input logic [AW-1:0] la, input logic lw, input logic [BW-1:0] lb, input logic [DW-1:0] ld,
                         input int stall, input int rsp_dly, input logic [DW-1:0] rd, input logic re,
                         input logic spur);
    @(negedge clk_i);
    ptw_req_i = p; ptw_addr_i = pa; ptw_we_i = pw; ptw_be_i = pb; ptw_wdata_i = pd;
    lsu_req_i = l; lsu_addr_i = la; lsu_we_i = lw; lsu_be_i = lb; lsu_wdata_i = ld;
    dc_gnt_i = 0; dc_rvalid_i = 0;
    #1;
    o_pgnt = ptw_gnt_o; o_lgnt = lsu_gnt_o; o_busy0 = busy_o;
    o_busy_ok = 1; o_regrant = 0; o_stable = 1; o_spur = 0; o_early_rv = 0;
    o_owner_hold = 1; o_wait_dcreq = 0;
    for (int i = 0; i <= stall; i++) begin
      @(negedge clk_i);
      scramble_reqs();
      dc_gnt_i = (i == stall); dc_rvalid_i = spur && (i == 0);
      dc_rdata_i = $urandom; dc_err_i = 1'($urandom_range(0, 1));
      #1;
      if (i == 0) begin
        o_owner = owner_o; o_addr = dc_addr_o; o_we = dc_we_o; o_be = dc_be_o; o_wdata = dc_wdata_o;
      end else if (dc_addr_o !== o_addr || dc_we_o !== o_we || dc_be_o !== o_be || dc_wdata_o !== o_wdata) begin
        o_stable = 0;
      end
      if (dc_req_o !== 1'b1 || busy_o !== 1'b1) o_busy_ok = 0;
      if (ptw_gnt_o || lsu_gnt_o) o_regrant = 1;
      if (spurious_o) o_spur = 1;
      if (ptw_rvalid_o || lsu_rvalid_o || ptw_err_o || lsu_err_o) o_early_rv = 1;
      if (owner_o !== o_owner) o_owner_hold = 0;
    end
    for (int j = 0; j <= rsp_dly; j++) begin
      @(negedge clk_i);
      scramble_reqs();
      dc_gnt_i = 1'($urandom_range(0, 1));
      dc_rvalid_i = (j == rsp_dly);
      dc_rdata_i = (j == rsp_dly) ? rd : $urandom;
      dc_err_i = (j == rsp_dly) ? re : 1'($urandom_range(0, 1));
      #1;
      if (dc_req_o !== 1'b0) o_wait_dcreq = 1;
      if (busy_o !== 1'b1) o_busy_ok = 0;
      if (ptw_gnt_o || lsu_gnt_o) o_regrant = 1;
      if (spurious_o) o_spur = 1;
      if (owner_o !== o_owner) o_owner_hold = 0;
      if (j < rsp_dly) begin
        if (ptw_rvalid_o || lsu_rvalid_o || ptw_err_o || lsu_err_o) o_early_rv = 1;
      end else begin
        o_p_rv = ptw_rvalid_o; o_l_rv = lsu_rvalid_o; o_p_err = ptw_err_o; o_l_err = lsu_err_o;
        o_p_rdata = ptw_rdata_o; o_l_rdata = lsu_rdata_o;
      end
    end
    @(negedge clk_i);
    idle_inputs();
    #1;
    o_busy_end = busy_o;
  endtask

  task automatic test_reset();
    rst_i = 1;
    idle_inputs();
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 0;
    #1;
    checks++;
    if ({busy_o, dc_req_o, owner_o, ptw_gnt_o, lsu_gnt_o, ptw_rvalid_o, lsu_rvalid_o, ptw_err_o, lsu_err_o, spurious_o} !== 10'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b expected 0", {busy_o, dc_req_o, owner_o, ptw_gnt_o, lsu_gnt_o, ptw_rvalid_o, lsu_rvalid_o, ptw_err_o, lsu_err_o, spurious_o});
    end
    checks++;
    if (dc_addr_o !== '0 || dc_we_o !== 1'b0 || dc_be_o !== '0 || dc_wdata_o !== '0) begin
      errors++; $display("FAIL reset_regs: got addr=%h we=%b be=%h wdata=%h expected all 0", dc_addr_o, dc_we_o, dc_be_o, dc_wdata_o);
    end
    wait_m = 0;
  endtask

  task automatic test_spurious_idle();
    @(negedge clk_i);
    dc_rvalid_i = 1; dc_rdata_i = 32'h1234_5678; dc_err_i = 1;
    #1;
    checks++;
    if (spurious_o !== 1'b1 || ptw_rvalid_o !== 1'b0 || lsu_rvalid_o !== 1'b0 || ptw_err_o !== 1'b0 || lsu_err_o !== 1'b0) begin
      errors++; $display("FAIL spurious_idle: got spur=%b prv=%b lrv=%b expected 1 0 0", spurious_o, ptw_rvalid_o, lsu_rvalid_o);
    end
    @(negedge clk_i);
    idle_inputs();
    #1;
    checks++;
    if (spurious_o !== 1'b0 || busy_o !== 1'b0) begin
      errors++; $display("FAIL spurious_pulse_end: got spur=%b busy=%b expected 0 0", spurious_o, busy_o);
    end
  endtask

  task automatic test_lsu_read();
    do_reset();
    run_txn(0, 1, 32'h0, 0, 4'h0, 32'h0, 32'h0000_1004, 0, 4'hF, 32'h0,
            1, 0, 32'hDEAD_BEEF, 0, 0);
    wait_m = 0;
    checks++;
    if (o_lgnt !== 1'b1 || o_pgnt !== 1'b0 || o_busy0 !== 1'b0) begin
      errors++; $display("FAIL lsu_read_gnt: got lgnt=%b pgnt=%b busy=%b expected 1 0 0", o_lgnt, o_pgnt, o_busy0);
    end
    checks++;
    if (o_busy_ok !== 1'b1 || o_addr !== 32'h0000_1004 || o_we !== 1'b0 || o_stable !== 1'b1) begin
      errors++; $display("FAIL lsu_read_issue: got ok=%b addr=%h we=%b expected 1 00001004 0", o_busy_ok, o_addr, o_we);
    end
    checks++;
    if (o_l_rv !== 1'b1 || o_l_rdata !== 32'hDEAD_BEEF || o_p_rv !== 1'b0 || o_early_rv !== 1'b0 || o_l_err !== 1'b0) begin
      errors++; $display("FAIL lsu_read_rsp: got lrv=%b data=%h prv=%b early=%b expected 1 deadbeef 0 0", o_l_rv, o_l_rdata, o_p_rv, o_early_rv);
    end
    checks++;
    if (o_owner !== 1'b1 || o_busy_end !== 1'b0 || o_wait_dcreq !== 1'b0 || o_regrant !== 1'b0) begin
      errors++; $display("FAIL lsu_read_misc: got owner=%b busy_end=%b wreq=%b regrant=%b expected 1 0 0 0", o_owner, o_busy_end, o_wait_dcreq, o_regrant);
    end
  endtask

  task automatic test_both_request();
    do_reset();
    run_txn(1, 1, 32'hA000, 0, 4'hF, 32'h0, 32'hB000, 0, 4'hF, 32'h0, 0, 0, 32'h1, 0, 0);
    checks++;
    if (o_pgnt !== 1'b1 || o_lgnt !== 1'b0 || o_owner !== 1'b0 || o_addr !== 32'hA000) begin
      errors++; $display("FAIL both_first: got pgnt=%b lgnt=%b owner=%b addr=%h expected 1 0 0 0000a000", o_pgnt, o_lgnt, o_owner, o_addr);
    end
    run_txn(0, 1, 32'h0, 0, 4'h0, 32'h0, 32'hB000, 0, 4'hF, 32'h0, 0, 0, 32'h2, 0, 0);
    wait_m = 0;
    checks++;
    if (o_lgnt !== 1'b1 || o_pgnt !== 1'b0 || o_owner !== 1'b1 || o_addr !== 32'hB000 || o_l_rv !== 1'b1) begin
      errors++; $display("FAIL both_second: got lgnt=%b pgnt=%b owner=%b addr=%h expected 1 0 1 0000b000", o_lgnt, o_pgnt, o_owner, o_addr);
    end
  endtask

  task automatic test_starvation();
    logic exp_l;
    do_reset();
    for (int k = 0; k < MW + 2; k++) begin
      run_txn(1, 1, 32'h100 + k, 0, 4'hF, 32'h0, 32'h200 + k, 1, 4'h3, 32'h55, 0, 1, 32'h0, 0, 0);
      exp_l = (k == MW);
      checks++;
      if (o_lgnt !== exp_l || o_pgnt !== !exp_l || o_owner !== exp_l) begin
        errors++; $display("FAIL starve_grant_%0d: got lgnt=%b pgnt=%b expected lgnt=%b", k, o_lgnt, o_pgnt, exp_l);
      end
    end
    wait_m = 1;
  endtask

  task automatic test_stall();
    run_txn(1, 0, 32'hCAFE_0000, 1, 4'hA, 32'h1357_9BDF, 32'h0, 0, 4'h0, 32'h0, 10, 2, 32'h0, 0, 0);
    checks++;
    if (o_stable !== 1'b1 || o_busy_ok !== 1'b1 || o_regrant !== 1'b0) begin
      errors++; $display("FAIL stall_hold: got stable=%b req_ok=%b regrant=%b expected 1 1 0", o_stable, o_busy_ok, o_regrant);
    end
    checks++;
    if (o_addr !== 32'hCAFE_0000 || o_we !== 1'b1 || o_be !== 4'hA || o_wdata !== 32'h1357_9BDF || o_p_rv !== 1'b1) begin
      errors++; $display("FAIL stall_fields: got addr=%h we=%b be=%h wdata=%h prv=%b", o_addr, o_we, o_be, o_wdata, o_p_rv);
    end
  endtask

  task automatic test_store_err();
    do_reset();
    run_txn(0, 1, 32'h0, 0, 4'h0, 32'h0, 32'h0000_2000, 1, 4'b0001, 32'h0000_00FF, 0, 1, 32'h0, 1, 0);
    wait_m = 0;
    checks++;
    if (o_we !== 1'b1 || o_be !== 4'b0001 || o_wdata !== 32'h0000_00FF) begin
      errors++; $display("FAIL store_fields: got we=%b be=%b wdata=%h expected 1 0001 000000ff", o_we, o_be, o_wdata);
    end
    checks++;
    if (o_l_rv !== 1'b1 || o_l_err !== 1'b1 || o_p_rv !== 1'b0 || o_p_err !== 1'b0) begin
      errors++; $display("FAIL store_err: got lrv=%b lerr=%b prv=%b perr=%b expected 1 1 0 0", o_l_rv, o_l_err, o_p_rv, o_p_err);
    end
  endtask

  task automatic test_reset_mid_txn();
    do_reset();
    @(negedge clk_i);
    lsu_req_i = 1; lsu_addr_i = 32'h7777_0000; lsu_we_i = 1; lsu_be_i = 4'hF; lsu_wdata_i = 32'h1;
    @(negedge clk_i);
    idle_inputs();
    dc_gnt_i = 1;
    @(negedge clk_i);
    dc_gnt_i = 0;
    rst_i = 1;
    #1;
    checks++;
    if (busy_o !== 1'b1 || owner_o !== 1'b1) begin
      errors++; $display("FAIL mid_pre_reset: got busy=%b owner=%b expected 1 1", busy_o, owner_o);
    end
    @(negedge clk_i);
    rst_i = 0;
    wait_m = 0;
    dc_rvalid_i = 1; dc_rdata_i = 32'hFFFF_0000; dc_err_i = 1;
    #1;
    checks++;
    if (busy_o !== 1'b0 || spurious_o !== 1'b1 || ptw_rvalid_o !== 1'b0 || lsu_rvalid_o !== 1'b0 || lsu_err_o !== 1'b0) begin
      errors++; $display("FAIL mid_reset_rsp: got busy=%b spur=%b prv=%b lrv=%b expected 0 1 0 0", busy_o, spurious_o, ptw_rvalid_o, lsu_rvalid_o);
    end
    checks++;
    if (owner_o !== 1'b0 || dc_addr_o !== '0 || dc_we_o !== 1'b0 || dc_req_o !== 1'b0) begin
      errors++; $display("FAIL mid_reset_regs: got owner=%b addr=%h we=%b req=%b expected 0 0 0 0", owner_o, dc_addr_o, dc_we_o, dc_req_o);
    end
    @(negedge clk_i);
    idle_inputs();
  endtask

  task automatic test_random();
    logic p, l, win_l, spur, re, pw, lw;
    logic [AW-1:0] pa, la, ea;
    logic [BW-1:0] pb, lb, eb;
    logic [DW-1:0] pd, ld, ed, rd;
    int stall, rsp;
    do_reset();
    for (int n = 0; n < 60; n++) begin
      p = 1'($urandom_range(0, 1)); l = 1'($urandom_range(0, 1));
      if (!p && !l) l = 1;
      if (n % 7 < 5) begin p = 1; l = 1; end
      pa = $urandom; la = $urandom; pd = $urandom; ld = $urandom; rd = $urandom;
      pw = 1'($urandom_range(0, 1)); lw = 1'($urandom_range(0, 1)); re = 1'($urandom_range(0, 1));
      pb = BW'($urandom); lb = BW'($urandom);
      stall = $urandom_range(0, 3); rsp = $urandom_range(0, 3);
      spur = ($urandom_range(0, 3) == 0);
      win_l = l && (!p || wait_m == MW);
      ea = win_l ? la : pa; eb = win_l ? lb : pb; ed = win_l ? ld : pd;
      run_txn(p, l, pa, pw, pb, pd, la, lw, lb, ld, stall, rsp, rd, re, spur);
      checks++;
      if (o_lgnt !== win_l || o_pgnt !== !win_l || o_owner !== win_l || o_owner_hold !== 1'b1) begin
        errors++; $display("FAIL rnd_grant_%0d: got lgnt=%b pgnt=%b owner=%b expected lsu=%b (wait=%0d)", n, o_lgnt, o_pgnt, o_owner, win_l, wait_m);
      end
      checks++;
      if (o_addr !== ea || o_we !== (win_l ? lw : pw) || o_be !== eb || o_wdata !== ed || o_stable !== 1'b1) begin
        errors++; $display("FAIL rnd_fields_%0d: got addr=%h be=%h wdata=%h expected %h %h %h", n, o_addr, o_be, o_wdata, ea, eb, ed);
      end
      checks++;
      if (o_busy0 !== 1'b0 || o_busy_ok !== 1'b1 || o_busy_end !== 1'b0 || o_regrant !== 1'b0 || o_wait_dcreq !== 1'b0) begin
        errors++; $display("FAIL rnd_proto_%0d: got busy0=%b ok=%b busy_end=%b regrant=%b wreq=%b", n, o_busy0, o_busy_ok, o_busy_end, o_regrant, o_wait_dcreq);
      end
      checks++;
      if (o_spur !== spur || o_early_rv !== 1'b0) begin
        errors++; $display("FAIL rnd_spur_%0d: got spur=%b early=%b expected %b 0", n, o_spur, o_early_rv, spur);
      end
      checks++;
      if (o_l_rv !== win_l || o_p_rv !== !win_l || o_l_err !== (win_l && re) || o_p_err !== (!win_l && re)
          || (win_l ? o_l_rdata : o_p_rdata) !== rd) begin
        errors++; $display("FAIL rnd_rsp_%0d: got lrv=%b prv=%b lerr=%b perr=%b expected lsu=%b err=%b data=%h", n, o_l_rv, o_p_rv, o_l_err, o_p_err, win_l, re, rd);
      end
      if (win_l) wait_m = 0;
      else if (l && wait_m < MW) wait_m++;
    end
  endtask

  initial begin
    test_reset();
    test_spurious_idle();
    test_lsu_read();
    test_both_request();
    test_starvation();
    test_stall();
    test_store_err();
    test_reset_mid_txn();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
